m_pcpi_issuer: RTL and testbench
================================

// Module: m_pcpi_issuer
// PURPOSE
//  Initiator side of the PCPI link: accepts one instruction request (insn, rs1, rs2) from the
//  core-side/bench, drives pcpi_valid/insn/rs1/rs2 to the M-unit coprocessor and waits for
//  pcpi_ready. Captures pcpi_wr/pcpi_rd and returns them on a held response port.
//  Raises rsp_trap (illegal insn) when no coprocessor claims the instruction within a timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  16  consecutive cycles with pcpi_busy=0 and pcpi_ready=0 before trap (>=1)
//  CYC_W           16  width of rsp_cycles latency counter (saturating)
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-high reset
//  req_valid    in   1      request present
//  req_ready    out  1      issuer can accept; high only in IDLE
//  req_insn     in   32     instruction word
//  req_rs1      in   32     operand 1
//  req_rs2      in   32     operand 2
//  pcpi_valid   out  1      instruction offered to coprocessor
//  pcpi_insn    out  32     registered copy of req_insn
//  pcpi_rs1     out  32     registered copy of req_rs1
//  pcpi_rs2     out  32     registered copy of req_rs2
//  pcpi_busy    in   1      coprocessor claims insn, still working (reloads timeout)
//  pcpi_ready   in   1      coprocessor done; pcpi_wr/pcpi_rd valid this cycle
//  pcpi_wr      in   1      result to be written back
//  pcpi_rd      in   32     result
//  rsp_valid    out  1      response held until rsp_ready
//  rsp_ready    in   1      consumer takes response
//  rsp_wr       out  1      captured pcpi_wr (0 on trap)
//  rsp_rd       out  32     captured pcpi_rd (0 on trap)
//  rsp_trap     out  1      timeout: no coprocessor answered
//  rsp_cycles   out  CYC_W  cycles pcpi_valid was high, incl. ready/expiry cycle; saturates at all-ones
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; every output 0 except req_ready=1; counters cleared.
//  - FSM IDLE -> ISSUE -> RESP -> IDLE. All outputs registered except req_ready (=state==IDLE).
//  - IDLE: req_valid at cycle N latches insn/rs1/rs2; pcpi_valid=1 from N+1; timeout loads
//    TIMEOUT_CYCLES-1; rsp_cycles clears.
//  - ISSUE, each cycle: rsp_cycles++ (sat).
//    pcpi_ready=1 -> capture wr/rd, trap=0; RESP next (pcpi_valid=0, rsp_valid=1 at next cycle).
//    else pcpi_busy=1 -> reload timeout; else count==0 -> trap, RESP next, wr=0, rd=0; else decrement.
//  - pcpi_ready wins over timeout expiry in the same cycle; pcpi_ready with pcpi_busy=0 is legal.
//  - pcpi_valid stays high continuously in ISSUE; insn/rs1/rs2 stable while pcpi_valid=1.
//  - RESP: rsp_* held stable; rsp_ready=1 -> rsp_valid=0, IDLE next cycle. No new request is
//    accepted in RESP (one idle cycle between back-to-back requests is required).
//  - pcpi_ready/busy outside ISSUE are ignored; req_valid outside IDLE is ignored (req_ready=0).
//  - Latency: ready sampled at M -> rsp_valid at M+1. Never busy -> trap at N+1+TIMEOUT_CYCLES.
//  - Reset mid-ISSUE drops pcpi_valid asynchronously; the request is discarded without a response.
// STRUCTURE
//  - m_definitions.svh: typedef enum logic [1:0] {ISS_IDLE, ISS_ISSUE, ISS_RESP} iss_state_t;
//    `PCPI_TIMEOUT_DEFAULT (16).
//  - One sub-module m_pcpi_timeout: load/reload/decrement down-counter, expired flag;
//    width $clog2(TIMEOUT_CYCLES)+1.
//  - Main file: FSM (always_ff async reset + always_comb next-state with defaults), operand/
//    response registers, saturating rsp_cycles.
// TESTING
//  1 MUL 0x02B50533, rs1=7, rs2=6; responder busy 3 cycles then ready with rd=42, wr=1 ->
//    rsp_valid, rsp_rd=42, rsp_wr=1, rsp_trap=0, rsp_cycles=4.
//  2 Unclaimed insn, busy/ready never asserted -> pcpi_valid high exactly 16 cycles, then
//    rsp_trap=1, rsp_rd=0, rsp_wr=0, rsp_cycles=16.
//  3 Busy held 40 cycles then ready with rd=0xFFFFFFFF -> no trap, rsp_rd=0xFFFFFFFF, rsp_cycles=41.
//  4 Ready on the 16th non-busy cycle (expiry cycle) -> rsp_trap=0, rd captured.
//  5 rsp_ready held low 5 cycles with req_valid=1 -> rsp_* stable, req_ready=0; request is
//    accepted the cycle after rsp_ready.
//  6 Reset at cycle 3 of ISSUE -> pcpi_valid=0 same cycle, rsp_valid never asserted, req_ready=1
//    after release.

Source files
------------

// File: rtl/m_pcpi_issuer_pkg.sv
// Shared types and defaults for the PCPI issuer: FSM state encoding and parameter defaults.
package m_pcpi_issuer_pkg;

  typedef enum logic [1:0] {
    ISS_IDLE,
    ISS_ISSUE,
    ISS_RESP
  } iss_state_t;

  localparam int PCPI_TIMEOUT_DEFAULT = 16;
  localparam int PCPI_CYC_W_DEFAULT   = 16;

endpackage

// File: rtl/m_pcpi_timeout.sv
// Claim-timeout down-counter: load/reload to TIMEOUT_CYCLES-1, decrement while unclaimed.
// expired is combinational from the count; the count stops at zero.
module m_pcpi_timeout #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic expired
);

  localparam int             W        = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [W-1:0]   LOAD_VAL = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/m_pcpi_issuer.sv
// PCPI initiator: one request in flight, response ready one cycle after pcpi_ready or timeout.
// Request accepted only in IDLE; response held until rsp_ready, then one IDLE cycle before next accept.
module m_pcpi_issuer
  import m_pcpi_issuer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = PCPI_TIMEOUT_DEFAULT,
  parameter int CYC_W          = PCPI_CYC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_insn,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  output logic             pcpi_valid,
  output logic [31:0]      pcpi_insn,
  output logic [31:0]      pcpi_rs1,
  output logic [31:0]      pcpi_rs2,
  input  logic             pcpi_busy,
  input  logic             pcpi_ready,
  input  logic             pcpi_wr,
  input  logic [31:0]      pcpi_rd,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_wr,
  output logic [31:0]      rsp_rd,
  output logic             rsp_trap,
  output logic [CYC_W-1:0] rsp_cycles
);

  iss_state_t state, next_state;
  logic       accept, done_hit, trap_hit, tmo_load, tmo_dec, expired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ISS_IDLE;
    else       state <= next_state;
  end

  // pcpi_ready is checked first so it wins over a same-cycle timeout expiry.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    done_hit   = 1'b0;
    trap_hit   = 1'b0;
    tmo_load   = 1'b0;
    tmo_dec    = 1'b0;
    case (state)
      ISS_IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          tmo_load   = 1'b1;
          next_state = ISS_ISSUE;
        end
      end
      ISS_ISSUE: begin
        if (pcpi_ready) begin
          done_hit   = 1'b1;
          next_state = ISS_RESP;
        end else if (pcpi_busy) begin
          tmo_load   = 1'b1;
        end else if (expired) begin
          trap_hit   = 1'b1;
          next_state = ISS_RESP;
        end else begin
          tmo_dec    = 1'b1;
        end
      end
      ISS_RESP: begin
        if (rsp_ready) next_state = ISS_IDLE;
      end
      default: next_state = ISS_IDLE;
    endcase
  end

  assign req_ready = (state == ISS_IDLE);

  m_pcpi_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .load    (tmo_load),
    .dec     (tmo_dec),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcpi_valid <= 1'b0;
      pcpi_insn  <= '0;
      pcpi_rs1   <= '0;
      pcpi_rs2   <= '0;
      rsp_valid  <= 1'b0;
      rsp_wr     <= 1'b0;
      rsp_rd     <= '0;
      rsp_trap   <= 1'b0;
      rsp_cycles <= '0;
    end else begin
      pcpi_valid <= (next_state == ISS_ISSUE);
      rsp_valid  <= (next_state == ISS_RESP);
      if (accept) begin
        pcpi_insn  <= req_insn;
        pcpi_rs1   <= req_rs1;
        pcpi_rs2   <= req_rs2;
        rsp_cycles <= '0;
      end
      if ((state == ISS_ISSUE) && (rsp_cycles != {CYC_W{1'b1}})) begin
        rsp_cycles <= rsp_cycles + CYC_W'(1);
      end
      if (done_hit) begin
        rsp_wr   <= pcpi_wr;
        rsp_rd   <= pcpi_rd;
        rsp_trap <= 1'b0;
      end else if (trap_hit) begin
        rsp_wr   <= 1'b0;
        rsp_rd   <= '0;
        rsp_trap <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_m_pcpi_issuer.sv
// Bench for m_pcpi_issuer: directed requests with a scripted coprocessor, scoreboard-checked responses.
module tb_m_pcpi_issuer;

  localparam int TO = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_insn, req_rs1, req_rs2;
  logic          pcpi_valid;
  logic [31:0]   pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic          pcpi_busy, pcpi_ready, pcpi_wr;
  logic [31:0]   pcpi_rd;
  logic          rsp_valid, rsp_ready, rsp_wr, rsp_trap;
  logic [31:0]   rsp_rd;
  logic [CW-1:0] rsp_cycles;

  typedef struct packed {
    logic          wr;
    logic [31:0]   rd;
    logic          trap;
    logic [CW-1:0] cycles;
  } rsp_t;

  rsp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          vtotal = 0;
  int          vbase  = 0;
  logic [31:0] exp_insn = '0, exp_rs1 = '0, exp_rs2 = '0;

  always #5 clk = ~clk;

  m_pcpi_issuer #(.TIMEOUT_CYCLES(TO), .CYC_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_busy(pcpi_busy), .pcpi_ready(pcpi_ready), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr), .rsp_rd(rsp_rd),
    .rsp_trap(rsp_trap), .rsp_cycles(rsp_cycles)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every response handshake pops one expectation.
  task automatic monitor();
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (pcpi_valid) begin
          vtotal++;
          chk("pcpi_insn", pcpi_insn, exp_insn);
          chk("pcpi_rs1", pcpi_rs1, exp_rs1);
          chk("pcpi_rs2", pcpi_rs2, exp_rs2);
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_wr", 32'(rsp_wr), 32'(e.wr));
            chk("rsp_rd", rsp_rd, e.rd);
            chk("rsp_trap", 32'(rsp_trap), 32'(e.trap));
            chk("rsp_cycles", 32'(rsp_cycles), 32'(e.cycles));
          end
        end
      end
    end
  endtask

  task automatic push_exp(input logic wr, input logic [31:0] rd, input logic trap, input int cyc);
    rsp_t e;
    e.wr = wr; e.rd = rd; e.trap = trap; e.cycles = CW'(cyc);
    exp_q.push_back(e);
  endtask

  task automatic issue_req(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    int t = 0;
    while (!req_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    exp_insn = i; exp_rs1 = a; exp_rs2 = b;
    req_insn = i; req_rs1 = a; req_rs2 = b;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    vbase = vtotal;
    chk("pcpi_valid_rise", 32'(pcpi_valid), 32'd1);
  endtask

  // Scripted coprocessor: busy_n busy cycles, idle_n silent cycles, then optionally one ready cycle.
  task automatic respond(input int busy_n, input int idle_n, input bit answer,
                         input logic wr, input logic [31:0] rd);
    if (busy_n > 0) begin
      pcpi_busy = 1'b1;
      repeat (busy_n) begin @(posedge clk); #1; end
      pcpi_busy = 1'b0;
    end
    repeat (idle_n) begin @(posedge clk); #1; end
    if (answer) begin
      pcpi_ready = 1'b1; pcpi_wr = wr; pcpi_rd = rd;
      @(posedge clk); #1;
      pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = '0;
    end
  endtask

  task automatic wait_rsp();
    int t = 0;
    while (!rsp_valid && t < 100) begin
      @(posedge clk); #1; t++;
    end
    chk("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    chk("pcpi_valid_low", 32'(pcpi_valid), 32'd0);
  endtask

  initial begin
    int seen;
    reset = 1'b1; req_valid = 1'b0; req_insn = '0; req_rs1 = '0; req_rs2 = '0;
    pcpi_busy = 1'b0; pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = '0; rsp_ready = 1'b1;
    fork
      monitor();
    join_none
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_pcpi_valid", 32'(pcpi_valid), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_trap", 32'(rsp_trap), 32'd0);
    chk("rst_rsp_cycles", 32'(rsp_cycles), 32'd0);
    chk("rst_pcpi_insn", pcpi_insn, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // MUL, busy 3 cycles then ready
    push_exp(1'b1, 32'd42, 1'b0, 4);
    issue_req(32'h02B5_0533, 32'd7, 32'd6);
    respond(3, 0, 1'b1, 1'b1, 32'd42);
    wait_rsp();
    chk("t1_valid_cycles", 32'(vtotal - vbase), 32'd4);

    // Unclaimed instruction traps after the timeout
    push_exp(1'b0, 32'd0, 1'b1, 16);
    issue_req(32'h0000_000B, 32'h1111_1111, 32'h2222_2222);
    respond(0, 0, 1'b0, 1'b0, 32'd0);
    wait_rsp();
    chk("t2_valid_cycles", 32'(vtotal - vbase), 32'd16);

    // Long busy keeps reloading the timeout
    push_exp(1'b1, 32'hFFFF_FFFF, 1'b0, 41);
    issue_req(32'h02C5_8633, 32'hFFFF_FFFF, 32'd1);
    respond(40, 0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    wait_rsp();

    // Ready on the expiry cycle beats the trap
    push_exp(1'b1, 32'h0000_ABCD, 1'b0, 16);
    issue_req(32'h02D6_C6B3, 32'd3, 32'd5);
    respond(0, 15, 1'b1, 1'b1, 32'h0000_ABCD);
    wait_rsp();

    // Response backpressure with a waiting request
    push_exp(1'b1, 32'h0000_1234, 1'b0, 1);
    push_exp(1'b0, 32'h0000_0055, 1'b0, 1);
    rsp_ready = 1'b0;
    issue_req(32'h02E7_0733, 32'd9, 32'd8);
    respond(0, 0, 1'b1, 1'b1, 32'h0000_1234);
    chk("t5_rsp_valid_up", 32'(rsp_valid), 32'd1);
    exp_insn = 32'h02F7_87B3; exp_rs1 = 32'd100; exp_rs2 = 32'd200;
    req_insn = exp_insn; req_rs1 = exp_rs1; req_rs2 = exp_rs2;
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("t5_hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t5_hold_rsp_rd", rsp_rd, 32'h0000_1234);
      chk("t5_hold_rsp_wr", 32'(rsp_wr), 32'd1);
      chk("t5_hold_rsp_cycles", 32'(rsp_cycles), 32'd1);
      chk("t5_hold_req_ready", 32'(req_ready), 32'd0);
      chk("t5_hold_pcpi_valid", 32'(pcpi_valid), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5_idle_req_ready", 32'(req_ready), 32'd1);
    chk("t5_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_idle_pcpi_valid", 32'(pcpi_valid), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    vbase = vtotal;
    chk("t5_accept_pcpi_valid", 32'(pcpi_valid), 32'd1);
    respond(0, 0, 1'b1, 1'b0, 32'h0000_0055);
    wait_rsp();

    // Reset in the third ISSUE cycle discards the request
    issue_req(32'h0300_0033, 32'd1, 32'd2);
    pcpi_busy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("t6_pcpi_valid_async", 32'(pcpi_valid), 32'd0);
    chk("t6_rsp_valid_rst", 32'(rsp_valid), 32'd0);
    chk("t6_req_ready_rst", 32'(req_ready), 32'd1);
    pcpi_busy = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    chk("t6_no_rsp", 32'(seen), 32'd0);
    chk("t6_req_ready_after", 32'(req_ready), 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
